// File: rtl/led_fade_driver.sv
// led_fade_driver: accepts an N_LED on/off pattern over valid/ready, ramps each
// channel's 8-bit level toward 0 or 255 every FADE_DIV cycles, and drives 8-bit PWM.
// Optional build macro LED_FADE_GAMMA_EN: squared (gamma) duty instead of linear duty.
module led_fade_driver #(
  parameter int N_LED     = 4,
  parameter int FADE_DIV  = 65536,
  parameter int FADE_STEP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_LED-1:0] in_pattern,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic [N_LED-1:0] led
);

  localparam int             PW           = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0]  PRESCALE_MAX = PW'(FADE_DIV - 1);
  localparam logic [8:0]     STEP9        = 9'(FADE_STEP);

  typedef enum logic {S_IDLE, S_FADING} state_t;

  state_t           r_state;
  logic [7:0]       r_level [N_LED];
  logic [N_LED-1:0] r_target;
  logic [7:0]       r_pwm_cnt;
  logic [PW-1:0]    r_prescale;
  logic [N_LED-1:0] r_led;

  logic             w_tick;
  logic             w_accept;
  logic [7:0]       w_level_next [N_LED];
  logic [N_LED-1:0] w_at_tgt_next;
  logic [N_LED-1:0] w_mismatch_new;
  logic [7:0]       w_duty [N_LED];

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_FADING);
  assign w_accept = in_valid & in_ready;
  assign w_tick   = (r_prescale == PRESCALE_MAX);
  assign led      = r_led;

  // Next fade level per channel: one step toward 0/255, clamped in 9 bits so it never wraps
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      w_level_next[i] = r_level[i];
      if (r_target[i]) begin
        if (({1'b0, r_level[i]} + STEP9) > 9'd255)
          w_level_next[i] = 8'd255;
        else
          w_level_next[i] = r_level[i] + STEP9[7:0];
      end else begin
        if ({1'b0, r_level[i]} < STEP9)
          w_level_next[i] = 8'd0;
        else
          w_level_next[i] = r_level[i] - STEP9[7:0];
      end
      w_at_tgt_next[i]  = (w_level_next[i] == {8{r_target[i]}});
      w_mismatch_new[i] = (r_level[i] != {8{in_pattern[i]}});
    end
  end

  // Duty per channel: linear by default, squared level when gamma is enabled
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
`ifdef LED_FADE_GAMMA_EN
      w_duty[i] = 8'((16'(r_level[i]) * 16'(r_level[i])) >> 8);
`else
      w_duty[i] = r_level[i];
`endif
    end
  end

  // Free-running PWM phase counter, wraps 255 -> 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pwm_cnt <= 8'd0;
    else         r_pwm_cnt <= r_pwm_cnt + 8'd1;
  end

  // Fade prescaler; restarted on accept so the first step lands FADE_DIV cycles later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_prescale <= '0;
    else if (w_accept || w_tick) r_prescale <= '0;
    else                         r_prescale <= r_prescale + PW'(1);
  end

  // Handshake/fade FSM owning target and level state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      for (int i = 0; i < N_LED; i++) r_level[i] <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_target <= in_pattern;
            // A pattern that already matches every level is consumed without fading
            if (|w_mismatch_new) r_state <= S_FADING;
          end
        end
        S_FADING: begin
          if (w_tick) begin
            for (int i = 0; i < N_LED; i++) r_level[i] <= w_level_next[i];
            if (&w_at_tgt_next) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered PWM output; full level forces a constant-on output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++)
        r_led[i] <= (r_level[i] == 8'hFF) | (r_pwm_cnt < w_duty[i]);
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: closed-form fade model (level = start +/- ticks*step,
// clamped) drives a per-cycle compare of led/busy/in_ready, plus literal pins per scenario.
module tb_led_fade_driver;

  localparam int FD = 4;
  localparam int FS = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] in_pattern = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, busy;
  logic [3:0] led;

  logic [3:0] in_pattern2 = 4'd0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, busy2;
  logic [3:0] led2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_fade_driver #(.N_LED(4), .FADE_DIV(FD), .FADE_STEP(FS)) u_dut (
    .clk(clk), .resetn(resetn), .in_pattern(in_pattern), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .led(led)
  );

  // Slow prescaler so level 128 holds for a full PWM period
  led_fade_driver #(.N_LED(4), .FADE_DIV(512), .FADE_STEP(128)) u_pwm (
    .clk(clk), .resetn(resetn), .in_pattern(in_pattern2), .in_valid(in_valid2),
    .in_ready(in_ready2), .busy(busy2), .led(led2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_lvl   [4];
  int         m_start [4];
  logic [3:0] m_tgt;
  bit         m_busy;
  int         m_el;
  int         m_pwm;
  logic [3:0] m_led;

  function automatic int lvl_at(int s, bit t, int k);
    int v;
    if (t) begin v = s + k * FS; if (v > 255) v = 255; end
    else   begin v = s - k * FS; if (v < 0)   v = 0;   end
    return v;
  endfunction

  function automatic int duty(int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) / 256;
`else
    return l;
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin m_lvl[i] = 0; m_start[i] = 0; end
      m_tgt = 4'd0; m_busy = 1'b0; m_el = 0; m_pwm = 0; m_led = 4'd0;
    end else begin
      bit done;
      for (int i = 0; i < 4; i++)
        m_led[i] = (m_lvl[i] == 255) || (m_pwm < duty(m_lvl[i]));
      m_pwm = (m_pwm + 1) % 256;
      if (!m_busy) begin
        if (in_valid) begin
          m_tgt = in_pattern;
          m_el  = 0;
          for (int i = 0; i < 4; i++) begin
            m_start[i] = m_lvl[i];
            if (m_lvl[i] != (m_tgt[i] ? 255 : 0)) m_busy = 1'b1;
          end
        end
      end else begin
        m_el++;
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
          m_lvl[i] = lvl_at(m_start[i], m_tgt[i], m_el / FD);
          if (m_lvl[i] != (m_tgt[i] ? 255 : 0)) done = 1'b0;
        end
        if (done) m_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (chk_on && resetn) begin
      chk("led",      32'(led),      32'(m_led));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic to_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] p, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    in_pattern = p;
    in_valid   = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int a, b, c, d, e, f, g, cnt, exp_cnt;

    // 1. reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk_on = 1'b1;
    to_cyc(cyc + 1000);
    chk("idle_led",   32'(led), 0);
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_busy",  32'(busy), 0);
    chk("idle_lvl0",  32'(m_lvl[0]), 0);

    // 2. fade up 1010, with 0101 held off during the fade (3)
    send(4'b1010, a);
    to_cyc(a + 1);
    chk("up_busy_rise", 32'(busy), 1);
    chk("up_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    in_pattern = 4'b0101;
    in_valid   = 1'b1;
    to_cyc(a + 4);
    chk("up_lvl3_t1", 32'(m_lvl[3]), 64);
    chk("up_lvl1_t1", 32'(m_lvl[1]), 64);
    chk("up_lvl2_t1", 32'(m_lvl[2]), 0);
    to_cyc(a + 8);
    chk("up_lvl3_t2", 32'(m_lvl[3]), 128);
    to_cyc(a + 12);
    chk("up_lvl1_t3", 32'(m_lvl[1]), 192);
    to_cyc(a + 15);
    chk("up_busy_before_t4", 32'(busy), 1);
    to_cyc(a + 16);
    chk("up_lvl3_t4",   32'(m_lvl[3]), 255);
    chk("up_busy_fall", 32'(busy), 0);
    chk("up_ready_rise", 32'(in_ready), 1);
    to_cyc(a + 17);
    b = a + 17;
    chk("hold_accepted", 32'(busy), 1);
    chk("hold_tgt",      32'(m_tgt), 32'h5);
    chk("up_led_full",   32'(led), 32'hA);
    @(negedge clk);
    in_valid = 1'b0;
    to_cyc(b + 4);
    chk("dn_lvl3_t1", 32'(m_lvl[3]), 191);
    chk("dn_lvl0_t1", 32'(m_lvl[0]), 64);
    to_cyc(b + 16);
    chk("dn_busy_fall", 32'(busy), 0);
    for (int k = 17; k <= 316; k++) begin
      to_cyc(b + k);
      chk("steady_led", 32'(led), 32'h5);
    end

    // 4. null transfer
    send(4'b0101, c);
    to_cyc(c + 1);
    chk("null_busy",  32'(busy), 0);
    chk("null_ready", 32'(in_ready), 1);
    to_cyc(c + 20);
    chk("null_busy_later", 32'(busy), 0);

    // back to all-off, then 6. reset mid-fade
    send(4'b0000, d);
    to_cyc(d + 16);
    chk("off_busy", 32'(busy), 0);
    send(4'b1111, e);
    to_cyc(e + 9);
    chk("mid_lvl0", 32'(m_lvl[0]), 128);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_led",   32'(led), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_lvl0",  32'(m_lvl[0]), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    send(4'b1111, f);
    to_cyc(f + 4);
    chk("restart_lvl2_t1", 32'(m_lvl[2]), 64);
    to_cyc(f + 15);
    chk("restart_busy", 32'(busy), 1);
    to_cyc(f + 16);
    chk("restart_done", 32'(busy), 0);
    to_cyc(f + 17);
    chk("restart_led", 32'(led), 32'hF);

    // 5. PWM duty at level 128 on the slow instance
    @(negedge clk);
    chk("pwm_ready", 32'(in_ready2), 1);
    in_pattern2 = 4'b0001;
    in_valid2   = 1'b1;
    @(posedge clk); #1;
    g = cyc;
    @(negedge clk);
    in_valid2 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      to_cyc(g + 513 + k);
      cnt += int'(led2[0]);
      if (led2[3:1] != 3'd0) chk("pwm_others_off", 32'(led2[3:1]), 0);
    end
`ifdef LED_FADE_GAMMA_EN
    exp_cnt = 64;
`else
    exp_cnt = 128;
`endif
    chk("pwm_high_count", 32'(cnt), 32'(exp_cnt));
    chk("pwm_busy", 32'(busy2), 1);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
